if_fetch_queue: RTL and testbench

Fetch stage directly downstream of the BTB/PC unit. Accepts the predicted PC and predict-taken bit each cycle, issues in-order requests to instruction memory, and buffers the returned instructions. Presents them in program order to the ID stage (the IF/ID boundary) with a valid/ready stall handshake. On a branch mispredict flush it discards queued entries and all in-flight responses.

---
 rtl/if_fetch_queue.sv | 136 +++++++++++++
 tb/tb_if_fetch_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue between the PC/BTB unit and the ID stage.
// Issues memory requests, buffers responses and drops stale ones after a flush.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_pred_taken,
  input  logic          pc_valid,
  output logic          pc_accept,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          flush,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc_plus4,
  output logic          id_pred_taken
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_filled;
  logic [DEPTH-1:0] ent_pred;
  logic [AW-1:0]    ent_pc    [DEPTH];
  logic [31:0]      ent_instr [DEPTH];

  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0] alloc_cnt, drop_cnt;
  logic [CW-1:0] unfilled_cnt, flush_drop;
  logic [SW-1:0] drop_sum;

  logic [AW-1:0] hold_pc;
  logic [31:0]   hold_instr;
  logic          hold_pred;

  logic has_room, do_fill, do_drop, do_deq;

  // Drop slots still count against capacity so stale responses never alias live entries.
  assign has_room  = (SW'(alloc_cnt) + SW'(drop_cnt)) < SW'(DEPTH);
  assign imem_req  = rst_n & pc_valid & ~flush & has_room;
  assign imem_addr = pc_in;
  assign pc_accept = imem_req & imem_gnt;

  assign do_drop  = imem_rvalid & (drop_cnt != '0) & ~flush;
  assign do_fill  = imem_rvalid & (drop_cnt == '0) & ~flush;
  assign id_valid = ent_valid[head_ptr] & ent_filled[head_ptr];
  assign do_deq   = id_valid & id_ready & ~flush;

  // Responses still owed to entries that a flush is about to discard.
  always_comb begin
    unfilled_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unfilled_cnt = unfilled_cnt + CW'(ent_valid[PW'(i)] & ~ent_filled[PW'(i)]);
    end
    drop_sum = SW'(drop_cnt) + SW'(unfilled_cnt);
    if (imem_rvalid && (drop_sum != '0)) begin
      drop_sum = drop_sum - SW'(1);
    end
    flush_drop = CW'(drop_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid  <= '0;
      ent_filled <= '0;
      ent_pred   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[PW'(i)]    <= '0;
        ent_instr[PW'(i)] <= '0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      ent_valid  <= '0;
      ent_filled <= '0;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      alloc_cnt  <= '0;
      drop_cnt   <= flush_drop;
    end else begin
      if (pc_accept) begin
        ent_valid[alloc_ptr]  <= 1'b1;
        ent_filled[alloc_ptr] <= 1'b0;
        ent_pc[alloc_ptr]     <= pc_in;
        ent_pred[alloc_ptr]   <= pc_pred_taken;
        alloc_ptr             <= alloc_ptr + PW'(1);
      end
      if (do_fill) begin
        ent_instr[fill_ptr]  <= imem_rdata;
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (do_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (do_deq) begin
        ent_valid[head_ptr] <= 1'b0;
        head_ptr            <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(pc_accept) - CW'(do_deq);
    end
  end

  // Last presented head, so the ID-side data holds while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc    <= '0;
      hold_instr <= '0;
      hold_pred  <= 1'b0;
    end else if (id_valid) begin
      hold_pc    <= ent_pc[head_ptr];
      hold_instr <= ent_instr[head_ptr];
      hold_pred  <= ent_pred[head_ptr];
    end
  end

  assign id_pc         = id_valid ? ent_pc[head_ptr]    : hold_pc;
  assign id_instr      = id_valid ? ent_instr[head_ptr] : hold_instr;
  assign id_pred_taken = id_valid ? ent_pred[head_ptr]  : hold_pred;
  assign id_pc_plus4   = id_pc + AW'(4);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: memory model with programmable latency
// and an in-order scoreboard compared at every ID-side dequeue.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_pred_taken;
  logic        pc_valid;
  logic        pc_accept;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_pred_taken;

  if_fetch_queue #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_in(pc_in), .pc_pred_taken(pc_pred_taken), .pc_valid(pc_valid),
    .pc_accept(pc_accept),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_pred_taken(id_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] instr;
  } exp_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  int          acc_cyc[$];
  int          deq_cyc[$];
  logic [31:0] deq_pc[$];
  logic [31:0] deq_p4[$];
  logic        deq_pred[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 1;
  logic s_req, s_acc, s_idv;
  logic [31:0] s_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h0000_0013;
  endfunction

  // One clock: sample settled outputs, update models and scoreboard, advance, drive rvalid.
  task automatic cycle();
    mreq_t m;
    exp_t  e;
    logic [31:0] p4;
    #1;
    s_req = imem_req;
    s_acc = pc_accept;
    s_idv = id_valid;
    s_pc  = id_pc;
    if (rst_n) begin
      if (pc_accept) begin
        m.addr = pc_in;
        m.due  = cyc + lat;
        mq.push_back(m);
        e.pc = pc_in; e.pred = pc_pred_taken; e.instr = instr_of(pc_in);
        sb.push_back(e);
        acc_cyc.push_back(cyc);
      end
      if (id_valid && id_ready && !flush) begin
        deq_cyc.push_back(cyc);
        deq_pc.push_back(id_pc);
        deq_p4.push_back(id_pc_plus4);
        deq_pred.push_back(id_pred_taken);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got pc=%h instr=%h exp none", id_pc, id_instr);
        end else begin
          e  = sb.pop_front();
          p4 = e.pc + 32'd4;
          if (id_pc !== e.pc || id_instr !== e.instr || id_pred_taken !== e.pred || id_pc_plus4 !== p4) begin
            errors++;
            $display("FAIL sb_entry got pc=%h instr=%h pred=%b p4=%h exp pc=%h instr=%h pred=%b p4=%h",
                     id_pc, id_instr, id_pred_taken, id_pc_plus4, e.pc, e.instr, e.pred, p4);
          end
        end
      end
      if (flush) sb.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(m.addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && (sb.size() != 0 || mq.size() != 0); n++) cycle();
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); deq_cyc.delete(); deq_pc.delete(); deq_p4.delete(); deq_pred.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_valid = 1'b1; pc_in = 32'h1234; pc_pred_taken = 1'b1;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0; id_ready = 1'b0;
    #3;
    checks++;
    if (imem_req !== 1'b0 || pc_accept !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b acc=%b idv=%b exp 0 0 0", imem_req, pc_accept, id_valid);
    end
    checks++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h4 || id_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got pc=%h instr=%h p4=%h pred=%b exp 0 0 4 0",
               id_pc, id_instr, id_pc_plus4, id_pred_taken);
    end
    cycle(); cycle();
    rst_n = 1'b1; pc_valid = 1'b0; pc_pred_taken = 1'b0;
    cycle();
  endtask

  task automatic test_streaming();
    clear_logs();
    lat = 1; id_ready = 1'b1; pc_valid = 1'b1; pc_in = 32'h0;
    for (int i = 0; i < 20 && acc_cyc.size() < 3; i++) begin
      cycle();
      if (s_acc) pc_in = pc_in + 32'd4;
    end
    pc_valid = 1'b0;
    drain(20);
    checks++;
    if (acc_cyc.size() != 3 || acc_cyc[2] - acc_cyc[0] != 2) begin
      errors++;
      $display("FAIL stream_accepts got n=%0d exp 3 back-to-back", acc_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (deq_cyc.size() != 3 || deq_cyc[k] != acc_cyc[0] + 2 + k ||
            deq_pc[k] !== 32'(4 * k) || deq_p4[k] !== 32'(4 * k + 4)) begin
          errors++;
          $display("FAIL stream_out%0d got n=%0d exp pc=%h at cycle %0d", k, deq_cyc.size(),
                   32'(4 * k), acc_cyc[0] + 2 + k);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stream_left got %0d exp 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    lat = 1; id_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h0;
    repeat (8) begin
      cycle();
      if (s_acc) pc_in = pc_in + 32'd4;
    end
    checks++;
    if (acc_cyc.size() != 4 || s_acc !== 1'b0 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL full_stop got accepts=%0d acc=%b req=%b exp 4 0 0", acc_cyc.size(), s_acc, s_req);
    end
    checks++;
    if (s_idv !== 1'b1 || s_pc !== 32'h0) begin
      errors++;
      $display("FAIL stall_head got idv=%b pc=%h exp 1 00000000", s_idv, s_pc);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 10 && acc_cyc.size() < 5; i++) begin
      cycle();
      if (s_acc) pc_in = pc_in + 32'd4;
    end
    pc_valid = 1'b0;
    drain(20);
    checks++;
    if (acc_cyc.size() != 5 || deq_cyc.size() == 0 || acc_cyc[4] != deq_cyc[0] + 1) begin
      errors++;
      $display("FAIL resume_accept got accepts=%0d exp accept one cycle after first dequeue", acc_cyc.size());
    end
    checks++;
    if (deq_pc.size() != 5 || deq_pc[0] !== 32'h0 || deq_pc[1] !== 32'h4 ||
        deq_pc[2] !== 32'h8 || deq_pc[3] !== 32'hC || deq_pc[4] !== 32'h10) begin
      errors++;
      $display("FAIL drain_order got n=%0d exp 0,4,8,c,10", deq_pc.size());
    end
  endtask

  task automatic test_flush_inflight();
    int idv_hits = 0;
    clear_logs();
    lat = 3; id_ready = 1'b1; pc_valid = 1'b1; pc_in = 32'h200;
    repeat (3) begin
      cycle();
      pc_in = pc_in + 32'd4;
    end
    pc_valid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h40;
    repeat (4) begin
      cycle();
      if (s_acc) pc_valid = 1'b0;
      if (s_idv) idv_hits++;
    end
    pc_valid = 1'b0;
    drain(20);
    checks++;
    if (acc_cyc.size() != 4 || idv_hits != 0) begin
      errors++;
      $display("FAIL flush_drop got accepts=%0d early_valid=%0d exp 4 0", acc_cyc.size(), idv_hits);
    end
    checks++;
    if (deq_pc.size() != 1 || deq_pc[0] !== 32'h40 || sb.size() != 0) begin
      errors++;
      $display("FAIL flush_first got n=%0d left=%0d exp one output pc 00000040", deq_pc.size(), sb.size());
    end
  endtask

  task automatic test_flush_coincident();
    clear_logs();
    lat = 2; id_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h300;
    repeat (3) begin
      cycle();
      pc_in = pc_in + 32'd4;
    end
    pc_valid = 1'b0; flush = 1'b1; id_ready = 1'b1;
    cycle();
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h80;
    cycle();
    pc_valid = 1'b0;
    checks++;
    if (s_idv !== 1'b0) begin
      errors++;
      $display("FAIL coinc_head got idv=%b exp 0", s_idv);
    end
    drain(20);
    checks++;
    if (deq_pc.size() != 1 || deq_pc[0] !== 32'h80 || sb.size() != 0) begin
      errors++;
      $display("FAIL coinc_first got n=%0d left=%0d exp one output pc 00000080", deq_pc.size(), sb.size());
    end
  endtask

  task automatic test_pred_wrap();
    clear_logs();
    lat = 1; id_ready = 1'b1; pc_valid = 1'b1; pc_in = 32'hFFFF_FFFC; pc_pred_taken = 1'b1;
    cycle();
    pc_in = 32'h100; pc_pred_taken = 1'b0;
    cycle();
    pc_valid = 1'b0;
    drain(20);
    checks++;
    if (deq_pc.size() != 2 || deq_pred[0] !== 1'b1 || deq_p4[0] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_entry got n=%0d exp pred=1 p4=00000000", deq_pc.size());
    end
    checks++;
    if (deq_pc.size() != 2 || deq_pred[1] !== 1'b0 || deq_p4[1] !== 32'h104) begin
      errors++;
      $display("FAIL pred_clear got n=%0d exp pred=0 p4=00000104", deq_pc.size());
    end
  endtask

  task automatic test_reset_midstream();
    clear_logs();
    lat = 1; id_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h500;
    cycle();
    pc_in = 32'h504;
    cycle();
    pc_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if (s_idv !== 1'b1 || s_pc !== 32'h500) begin
      errors++;
      $display("FAIL prereset_head got idv=%b pc=%h exp 1 00000500", s_idv, s_pc);
    end
    pc_valid = 1'b1; pc_in = 32'h508;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0 || pc_accept !== 1'b0 || id_pc !== 32'h0 ||
        id_instr !== 32'h0 || id_pc_plus4 !== 32'h4 || id_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got idv=%b req=%b acc=%b pc=%h instr=%h p4=%h pred=%b exp 0 0 0 0 0 4 0",
               id_valid, imem_req, pc_accept, id_pc, id_instr, id_pc_plus4, id_pred_taken);
    end
    sb.delete(); mq.delete();
    imem_rvalid = 1'b0; imem_rdata = '0;
    cycle();
    rst_n = 1'b1; pc_in = 32'h0; pc_valid = 1'b1; id_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 10 && acc_cyc.size() < 1; i++) begin
      cycle();
      if (s_acc) pc_valid = 1'b0;
    end
    pc_valid = 1'b0;
    drain(20);
    checks++;
    if (deq_pc.size() != 1 || deq_pc[0] !== 32'h0 || sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset got n=%0d left=%0d exp one output pc 00000000", deq_pc.size(), sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_inflight();
    test_flush_coincident();
    test_pred_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
